// File: rtl/doa_frame_sequencer.sv
// doa_frame_sequencer
//   Frame scheduler for the DOA pipeline. One frame runs capture -> FFT -> freqdetect ->
//   beam-weight search. Each stage's done must arrive before the next stage starts. The
//   winning angle is published with a one-cycle valid pulse, and completed frames are counted.
//   A per-stage watchdog aborts a stalled frame and records a sticky error.
//
//   Optional feature: define DOA_AVG_EN to publish the floor-average of the last 4 captured
//   angles instead of the latest angle.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   run, single         continuous mode level / single-frame request pulse
//   cap_start/cap_done  capture handshake (start pulse out, done pulse in)
//   fft_start/fft_done  FFT handshake
//   det_start/det_done  freqdetect handshake (done is a level; its rising edge counts)
//   wb_done, wb_doa     weightblock completion pulse and signed angle
//   doa_out, doa_valid  published angle and update pulse
//   busy                FSM not idle
//   timeout_err         sticky stage-timeout flag
//   frame_cnt           completed-frame counter (wraps)
//   state_dbg           encoded FSM state
module doa_frame_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             single,
   output logic             cap_start,
   input  logic             cap_done,
   output logic             fft_start,
   input  logic             fft_done,
   output logic             det_start,
   input  logic             det_done,
   input  logic             wb_done,
   input  logic [7:0]       wb_doa,
   output logic [7:0]       doa_out,
   output logic             doa_valid,
   output logic             busy,
   output logic             timeout_err,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [2:0]       state_dbg
);

   localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StCapture = 3'd1,
      StFft     = 3'd2,
      StDetect  = 3'd3,
      StWeight  = 3'd4,
      StPublish = 3'd5
   } state_e;

   state_e            state_q, state_d;
   logic              single_pend_q, single_pend_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic              det_done_q, det_done_d;
   logic              cap_start_q, cap_start_d;
   logic              fft_start_q, fft_start_d;
   logic              det_start_q, det_start_d;
   logic [7:0]        doa_out_q, doa_out_d;
   logic              doa_valid_q, doa_valid_d;
   logic              busy_q, busy_d;
   logic              timeout_err_q, timeout_err_d;
   logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

`ifdef DOA_AVG_EN
   logic [3:0][7:0]   hist_q, hist_d;
   logic              hist_valid_q, hist_valid_d;
   logic [9:0]        avg_sum;
`endif

   logic done_ok;
   logic timed_out;
   logic start_req;
   logic entering;

   always_comb begin
      state_d       = state_q;
      single_pend_d = single_pend_q | single;
      timer_d       = timer_q;
      det_done_d    = det_done;
      cap_start_d   = 1'b0;
      fft_start_d   = 1'b0;
      det_start_d   = 1'b0;
      doa_out_d     = doa_out_q;
      doa_valid_d   = 1'b0;
      timeout_err_d = timeout_err_q;
      frame_cnt_d   = frame_cnt_q;
`ifdef DOA_AVG_EN
      hist_d        = hist_q;
      hist_valid_d  = hist_valid_q;
      avg_sum       = '0;
`endif

      // A done in the start-pulse cycle (timer still 0) is not accepted.
      done_ok   = (timer_q != '0);
      timed_out = (timer_q == TimerLast);
      start_req = run | single_pend_q | single;

      case (state_q)
         StIdle, StPublish: begin
            if (start_req) begin
               state_d       = StCapture;
               single_pend_d = 1'b0;
            end else begin
               state_d = StIdle;
            end
         end
         StCapture: begin
            if (done_ok && cap_done) begin
               state_d = StFft;
            end else if (timed_out) begin
               state_d       = StIdle;
               timeout_err_d = 1'b1;
`ifdef DOA_AVG_EN
               hist_valid_d  = 1'b0;
`endif
            end
         end
         StFft: begin
            if (done_ok && fft_done) begin
               state_d = StDetect;
            end else if (timed_out) begin
               state_d       = StIdle;
               timeout_err_d = 1'b1;
`ifdef DOA_AVG_EN
               hist_valid_d  = 1'b0;
`endif
            end
         end
         StDetect: begin
            if (done_ok && det_done && !det_done_q) begin
               state_d = StWeight;
            end else if (timed_out) begin
               state_d       = StIdle;
               timeout_err_d = 1'b1;
`ifdef DOA_AVG_EN
               hist_valid_d  = 1'b0;
`endif
            end
         end
         StWeight: begin
            if (done_ok && wb_done) begin
               state_d     = StPublish;
               doa_valid_d = 1'b1;
               frame_cnt_d = frame_cnt_q + CNT_W'(1);
`ifdef DOA_AVG_EN
               // First sample after reset/timeout seeds the whole history.
               if (hist_valid_q) begin
                  hist_d = {hist_q[2], hist_q[1], hist_q[0], wb_doa};
               end else begin
                  hist_d = {wb_doa, wb_doa, wb_doa, wb_doa};
               end
               hist_valid_d = 1'b1;
               avg_sum = {{2{hist_d[0][7]}}, hist_d[0]} + {{2{hist_d[1][7]}}, hist_d[1]}
                       + {{2{hist_d[2][7]}}, hist_d[2]} + {{2{hist_d[3][7]}}, hist_d[3]};
               // Bits [9:2] are the arithmetic shift right by 2 (floor division by 4).
               doa_out_d = avg_sum[9:2];
`else
               doa_out_d = wb_doa;
`endif
            end else if (timed_out) begin
               state_d       = StIdle;
               timeout_err_d = 1'b1;
`ifdef DOA_AVG_EN
               hist_valid_d  = 1'b0;
`endif
            end
         end
         default: state_d = StIdle;
      endcase

      entering = (state_d != state_q);
      if (entering || state_d == StIdle || state_d == StPublish) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + TimerW'(1);
      end

      cap_start_d = entering && (state_d == StCapture);
      fft_start_d = entering && (state_d == StFft);
      det_start_d = entering && (state_d == StDetect);
      busy_d      = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         single_pend_q <= 1'b0;
         timer_q       <= '0;
         det_done_q    <= 1'b0;
         cap_start_q   <= 1'b0;
         fft_start_q   <= 1'b0;
         det_start_q   <= 1'b0;
         doa_out_q     <= '0;
         doa_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
         frame_cnt_q   <= '0;
`ifdef DOA_AVG_EN
         hist_q        <= '0;
         hist_valid_q  <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         single_pend_q <= single_pend_d;
         timer_q       <= timer_d;
         det_done_q    <= det_done_d;
         cap_start_q   <= cap_start_d;
         fft_start_q   <= fft_start_d;
         det_start_q   <= det_start_d;
         doa_out_q     <= doa_out_d;
         doa_valid_q   <= doa_valid_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
         frame_cnt_q   <= frame_cnt_d;
`ifdef DOA_AVG_EN
         hist_q        <= hist_d;
         hist_valid_q  <= hist_valid_d;
`endif
      end
   end

   assign cap_start   = cap_start_q;
   assign fft_start   = fft_start_q;
   assign det_start   = det_start_q;
   assign doa_out     = doa_out_q;
   assign doa_valid   = doa_valid_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_err_q;
   assign frame_cnt   = frame_cnt_q;
   assign state_dbg   = state_q;

endmodule
